pwm_core: RTL and testbench
===========================

Name: pwm_core

Overview:
Downstream consumer of the divided clock (slow_clk) in the PWM timer. It runs a period counter that produces either a PWM waveform or a timer interrupt flag. Period and duty values come from the register file and are shadowed so that they update only at period boundaries. The block is the last stage before the o_pwm pad and the interrupt logic.

Parameters:
CNT_W, 16, width of counter, period and duty values

Ports:
slow_clk  input  1  divided clock; the only clock of this block
i_wb_rst  input  1  reset; synchronous, active-high
ctrl_en  input  1  run enable from the control register
ctrl_mode  input  1  0 = timer, 1 = PWM
ctrl_oneshot  input  1  1 = stop after one period; 0 = continuous
irq_clr  input  1  clears irq_flag; one-cycle pulse or level
period_reg  input  CNT_W  period in slow_clk cycles; 0 is invalid
duty_reg  input  CNT_W  high time in slow_clk cycles, PWM mode only
o_pwm  output  1  registered PWM output
irq_flag  output  1  sticky period-end flag
count  output  CNT_W  current counter value
busy  output  1  high while state is RUN

Behaviour:
- Clocking and reset
  - All state updates on posedge slow_clk.
  - i_wb_rst is sampled on the edge only (synchronous, active-high).
  - Reset values: state=IDLE, count=0, o_pwm=0, irq_flag=0, busy=0, period_sh=0, duty_sh=0.
  - Reset asserted mid-operation: all reset values apply at the next edge and take priority over every other event.
- States: IDLE, RUN, DONE.
- IDLE
  - If ctrl_en=1 and period_reg!=0:
    - period_sh<=period_reg, duty_sh<=duty_reg, count<=0, state<=RUN.
    - o_pwm<=ctrl_mode & (duty_reg!=0).
  - Otherwise stay in IDLE, count=0, o_pwm=0.
  - period_reg=0 keeps the block in IDLE (error handling).
- RUN, busy=1, each edge:
  - ctrl_en=0: state<=IDLE, count<=0, o_pwm<=0. irq_flag is retained.
  - count==period_sh-1 (wrap):
    - count<=0, irq_flag<=1.
    - period_sh and duty_sh reload from period_reg and duty_reg.
    - If period_reg is 0 at the wrap: state<=IDLE.
    - Else if ctrl_oneshot=1: state<=DONE.
  - Otherwise count<=count+1.
  - o_pwm is registered: o_pwm<=ctrl_mode & (next_count < next_duty_sh).
    - Result: high for duty_sh cycles starting at count 0, then low for period_sh-duty_sh cycles.
- DONE
  - count=0, o_pwm=0, busy=0.
  - Leaves to IDLE only when ctrl_en=0, so it never auto-restarts.
- Arithmetic
  - Compare is unsigned at CNT_W width; no overflow is possible because count < period_sh.
  - duty_sh>=period_sh gives o_pwm constantly 1 (100%).
  - duty_sh=0 gives o_pwm constantly 0.
- Timer mode: o_pwm is held at 0; irq_flag sets at every wrap.
- period_sh=1: wraps every cycle; irq_flag sets every cycle.
- irq_flag: set at wrap, cleared by irq_clr. Set and clear in the same cycle → set wins.
- Shadowing: changes to period_reg or duty_reg during RUN have no effect until the next wrap.
- Latency: the first o_pwm high cycle is the edge that enters RUN. irq_flag is visible period_sh edges after entry into RUN.

Decomposition:
- Shared package pwm_pkg:
  - state enum (IDLE, RUN, DONE)
  - CNT_W default
  - MODE_TIMER and MODE_PWM constants
- No sub-module: counter, compare and FSM fit one flat module of roughly 150 lines.

Test Plan:
1. Reset check: hold i_wb_rst for 5 edges with ctrl_en=1 → count=0, o_pwm=0, irq_flag=0, busy=0.
2. PWM continuous, period=10, duty=3, mode=1 → o_pwm repeats 3 high / 7 low over 3 periods; irq_flag=1 after the 10th RUN edge; busy stays 1.
3. Timer one-shot, period=5, mode=0, oneshot=1 → irq_flag=1 and state DONE after 5 edges; o_pwm=0 throughout; count=0; busy=0; irq_clr → irq_flag=0; ctrl_en=0 → IDLE.
4. Shadowing: period=10, duty=3; change duty to 7 at count=4 → current period stays 3 high; next period is 7 high / 3 low.
5. Corner values:
   - period=0 → stays IDLE, busy=0.
   - duty=0 → o_pwm constantly 0.
   - duty=12 with period=10 → o_pwm constantly 1.
   - period=1 → irq_flag sets every edge.
6. Simultaneous and mid-operation events:
   - irq_clr on the wrap edge → irq_flag=1.
   - i_wb_rst asserted at count=6 in RUN → all outputs 0 at the next edge.
   - ctrl_en dropped at count=4 → IDLE, count=0, o_pwm=0, irq_flag unchanged.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM timer core: FSM state encoding, the default
// counter width and the ctrl_mode encodings.
// -----------------------------------------------------------------------------
package pwm_pkg;

    // Default width of the counter, period and duty values
    localparam int CNT_W_DEF = 16;

    // ctrl_mode encodings
    localparam logic MODE_TIMER = 1'b0;
    localparam logic MODE_PWM   = 1'b1;

    // Period-counter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : pwm_pkg

// File: rtl/pwm_core.sv
// -----------------------------------------------------------------------------
// pwm_core
// Period counter running on the divided clock. In PWM mode it drives a
// registered waveform that is high for duty_sh cycles from count 0 and low for
// the rest of the period; in timer mode o_pwm stays low. Every period end sets
// a sticky irq_flag. Period and duty are shadowed and reload only at a wrap.
//
// Ports
//   slow_clk      divided clock, the only clock of this block
//   i_wb_rst      synchronous active-high reset
//   ctrl_en       run enable
//   ctrl_mode     0 = timer, 1 = PWM
//   ctrl_oneshot  1 = stop after one period, 0 = continuous
//   irq_clr       clears irq_flag (a wrap in the same cycle wins)
//   period_reg    period in slow_clk cycles, 0 is invalid
//   duty_reg      high time in slow_clk cycles (PWM mode)
//   o_pwm         registered PWM output
//   irq_flag      sticky period-end flag
//   count         current counter value
//   busy          high while the FSM is in RUN
// -----------------------------------------------------------------------------
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             slow_clk,
    input  logic             i_wb_rst,
    input  logic             ctrl_en,
    input  logic             ctrl_mode,
    input  logic             ctrl_oneshot,
    input  logic             irq_clr,
    input  logic [CNT_W-1:0] period_reg,
    input  logic [CNT_W-1:0] duty_reg,
    output logic             o_pwm,
    output logic             irq_flag,
    output logic [CNT_W-1:0] count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period_sh;
    logic [CNT_W-1:0] r_duty_sh;
    logic             r_pwm;
    logic             r_irq;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    logic             w_pwm_nxt;
    logic             w_irq_nxt;
    logic             w_busy_nxt;
    logic             w_wrap;

    // State register: reset has priority over every other event
    always_ff @(posedge slow_clk) begin
        if (i_wb_rst) begin
            r_state     <= IDLE;
            r_count     <= CNT_ZERO;
            r_period_sh <= CNT_ZERO;
            r_duty_sh   <= CNT_ZERO;
            r_pwm       <= 1'b0;
            r_irq       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_period_sh <= w_period_nxt;
            r_duty_sh   <= w_duty_nxt;
            r_pwm       <= w_pwm_nxt;
            r_irq       <= w_irq_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state, counter, shadow reload and output computation
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_period_nxt = r_period_sh;
        w_duty_nxt   = r_duty_sh;
        w_wrap       = 1'b0;

        case (r_state)
            IDLE: begin
                w_count_nxt = CNT_ZERO;
                // A zero period is invalid and keeps the block parked here
                if (ctrl_en && (period_reg != CNT_ZERO)) begin
                    w_period_nxt = period_reg;
                    w_duty_nxt   = duty_reg;
                    w_state_nxt  = RUN;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            RUN: begin
                if (!ctrl_en) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = CNT_ZERO;
                end else if (r_count == (r_period_sh - CNT_ONE)) begin
                    w_wrap       = 1'b1;
                    w_count_nxt  = CNT_ZERO;
                    w_period_nxt = period_reg;
                    w_duty_nxt   = duty_reg;
                    if (period_reg == CNT_ZERO) begin
                        w_state_nxt = IDLE;
                    end else if (ctrl_oneshot) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else begin
                    w_count_nxt = r_count + CNT_ONE;
                end
            end
            DONE: begin
                w_count_nxt = CNT_ZERO;
                // Only a dropped enable leaves DONE, so there is no auto-restart
                if (!ctrl_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = CNT_ZERO;
            end
        endcase

        // Waveform is computed from the values the counter will hold next, so
        // o_pwm lines up with count; duty >= period yields a constant high
        if ((w_state_nxt == RUN) && (ctrl_mode == MODE_PWM)) begin
            w_pwm_nxt = (w_count_nxt < w_duty_nxt);
        end else begin
            w_pwm_nxt = 1'b0;
        end

        // Set beats clear when both happen in the same cycle
        if (w_wrap) begin
            w_irq_nxt = 1'b1;
        end else if (irq_clr) begin
            w_irq_nxt = 1'b0;
        end else begin
            w_irq_nxt = r_irq;
        end

        w_busy_nxt = (w_state_nxt == RUN);
    end

    assign o_pwm    = r_pwm;
    assign irq_flag = r_irq;
    assign count    = r_count;
    assign busy     = r_busy;

endmodule : pwm_core

// File: tb/tb_pwm_core.sv
// -----------------------------------------------------------------------------
// tb_pwm_core
// Directed self-checking bench for pwm_core. Outputs are sampled 1 ns after
// each rising edge; inputs are changed at the same point, well away from the
// next edge.
// -----------------------------------------------------------------------------
module tb_pwm_core;

    localparam int W = 16;

    logic         slow_clk;
    logic         i_wb_rst;
    logic         ctrl_en;
    logic         ctrl_mode;
    logic         ctrl_oneshot;
    logic         irq_clr;
    logic [W-1:0] period_reg;
    logic [W-1:0] duty_reg;
    logic         o_pwm;
    logic         irq_flag;
    logic [W-1:0] count;
    logic         busy;

    int checks = 0;
    int errors = 0;

    pwm_core #(.CNT_W(W)) dut (
        .slow_clk     (slow_clk),
        .i_wb_rst     (i_wb_rst),
        .ctrl_en      (ctrl_en),
        .ctrl_mode    (ctrl_mode),
        .ctrl_oneshot (ctrl_oneshot),
        .irq_clr      (irq_clr),
        .period_reg   (period_reg),
        .duty_reg     (duty_reg),
        .o_pwm        (o_pwm),
        .irq_flag     (irq_flag),
        .count        (count),
        .busy         (busy)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_cnt, input logic e_pwm,
                           input logic e_irq, input logic e_busy);
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".pwm"},   32'(o_pwm), 32'(e_pwm));
        chk({tag, ".irq"},   32'(irq_flag), 32'(e_irq));
        chk({tag, ".busy"},  32'(busy), 32'(e_busy));
    endtask

    initial begin
        // 1. Reset held for 5 edges with enable high
        i_wb_rst = 1'b1; ctrl_en = 1'b1; ctrl_mode = 1'b1; ctrl_oneshot = 1'b0;
        irq_clr = 1'b0; period_reg = 16'd10; duty_reg = 16'd3;
        repeat (5) tick();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);

        // 2. PWM continuous, period 10, duty 3, three periods
        i_wb_rst = 1'b0;
        tick();
        for (int i = 0; i < 30; i++) begin
            chk_all($sformatf("pwm_cont[%0d]", i), i % 10, (i % 10) < 3, i >= 10, 1'b1);
            tick();
        end
        ctrl_en = 1'b0;
        tick();
        chk_all("pwm_cont_stop", 0, 1'b0, 1'b1, 1'b0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("irq_clr_idle", 32'(irq_flag), 32'd0);

        // 3. Timer one-shot, period 5
        ctrl_mode = 1'b0; ctrl_oneshot = 1'b1; period_reg = 16'd5; ctrl_en = 1'b1;
        tick();
        chk_all("oneshot_entry", 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_all($sformatf("oneshot[%0d]", i), i, 1'b0, 1'b0, 1'b1);
        end
        tick();
        chk_all("oneshot_done", 0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        chk_all("oneshot_hold", 0, 1'b0, 1'b1, 1'b0);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("oneshot_irq_clr", 32'(irq_flag), 32'd0);
        ctrl_en = 1'b0; tick();
        chk_all("oneshot_idle", 0, 1'b0, 1'b0, 1'b0);
        // From IDLE a fresh enable restarts, proving DONE was left
        ctrl_en = 1'b1; tick();
        chk("oneshot_restart.busy", 32'(busy), 32'd1);
        ctrl_en = 1'b0; tick();

        // 4. Shadowing: duty changed at count 4 takes effect after the wrap
        ctrl_mode = 1'b1; ctrl_oneshot = 1'b0; period_reg = 16'd10; duty_reg = 16'd3;
        ctrl_en = 1'b1;
        tick();
        repeat (4) tick();
        chk("shadow_at4.count", 32'(count), 32'd4);
        duty_reg = 16'd7;
        for (int i = 5; i < 20; i++) begin
            tick();
            chk($sformatf("shadow[%0d].count", i), 32'(count), 32'(i % 10));
            chk($sformatf("shadow[%0d].pwm", i), 32'(o_pwm),
                32'((i < 10) ? ((i % 10) < 3) : ((i % 10) < 7)));
        end
        ctrl_en = 1'b0; irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk_all("shadow_stop", 0, 1'b0, 1'b0, 1'b0);

        // 5a. period 0 stays IDLE
        period_reg = 16'd0; duty_reg = 16'd3; ctrl_en = 1'b1;
        repeat (2) tick();
        chk_all("period0", 0, 1'b0, 1'b0, 1'b0);
        ctrl_en = 1'b0; tick();

        // 5b. duty 0 gives constant low
        period_reg = 16'd10; duty_reg = 16'd0; ctrl_en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("duty0[%0d].pwm", i), 32'(o_pwm), 32'd0);
            tick();
        end
        ctrl_en = 1'b0; tick();

        // 5c. duty above period gives constant high
        duty_reg = 16'd12; ctrl_en = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("duty12[%0d].pwm", i), 32'(o_pwm), 32'd1);
            tick();
        end
        ctrl_en = 1'b0; irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk("duty12_clr.irq", 32'(irq_flag), 32'd0);

        // 5d. period 1 wraps every edge; a held clear loses to every wrap
        period_reg = 16'd1; duty_reg = 16'd0; ctrl_mode = 1'b0; ctrl_en = 1'b1;
        tick();
        chk_all("p1_entry", 0, 1'b0, 1'b0, 1'b1);
        irq_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("p1[%0d]", i), 0, 1'b0, 1'b1, 1'b1);
        end
        ctrl_en = 1'b0; tick();
        chk_all("p1_stop", 0, 1'b0, 1'b0, 1'b0);
        irq_clr = 1'b0;

        // 6a. irq_clr on the wrap edge: set wins
        period_reg = 16'd10; duty_reg = 16'd3; ctrl_mode = 1'b1; ctrl_en = 1'b1;
        tick();
        repeat (9) tick();
        chk("wrapclr_pre.count", 32'(count), 32'd9);
        irq_clr = 1'b1; tick(); irq_clr = 1'b0;
        chk_all("wrapclr", 0, 1'b1, 1'b1, 1'b1);

        // 6b. Reset at count 6 in RUN
        repeat (6) tick();
        chk("rst_pre.count", 32'(count), 32'd6);
        i_wb_rst = 1'b1; tick(); i_wb_rst = 1'b0;
        chk_all("rst_mid", 0, 1'b0, 1'b0, 1'b0);

        // 6c. Enable dropped at count 4 keeps irq_flag
        tick();
        repeat (10) tick();
        chk_all("endrop_wrap", 0, 1'b1, 1'b1, 1'b1);
        repeat (4) tick();
        chk("endrop_pre.count", 32'(count), 32'd4);
        ctrl_en = 1'b0; tick();
        chk_all("endrop", 0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_core
